// File: rtl/pipe_stage_hs.sv
// ---------------------------------------------------------------------------
// pipe_stage_hs
//
// Parametrised pipeline stage register with a valid/ready handshake.  It
// carries an opaque payload between two CPU pipeline stages and adds bubble
// insertion, a synchronous flush and a saturating stall counter.
//
// Build option (macro PIPE_SKID_EN):
//   undefined : one storage register; in_ready is combinational and
//               depends on out_ready.
//   defined   : main + skid entries; in_ready comes from a flop, so there
//               is no combinational out_ready -> in_ready path.
//   The port list is the same in both builds.
//
// Parameters
//   DATA_W  payload width in bits (>= 1)
//   CNT_W   stall counter width in bits (>= 1)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream beat present
//   in_ready   out  stage can accept a beat this cycle
//   in_data    in   upstream payload
//   out_valid  out  downstream beat present
//   out_ready  in   downstream accepts (0 = stall)
//   out_data   out  registered payload
//   flush      in   synchronous kill of every held beat
//   stall_cnt  out  cycles seen with out_valid=1 and out_ready=0
// ---------------------------------------------------------------------------
module pipe_stage_hs #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic xfer_in;
  logic xfer_out;

  assign xfer_in  = in_valid & in_ready;
  assign xfer_out = out_valid & out_ready;

`ifdef PIPE_SKID_EN

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] skid_data;
  // Registered "skid entry is free"; flush only gates it on the way out.
  logic              ready_q;

  assign in_ready = ~flush & ready_q;

  // out_data is the main entry; the skid entry parks the beat that arrived
  // while the main entry was stalled.  On a drain from SKID the parked beat
  // moves to main, so the head of the stream is always on out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too, so no payload from before
      // a reset can reappear on out_data.
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
      ready_q   <= 1'b1;
    end else if (flush) begin
      // Kill both entries; payload registers keep their contents.
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge values of state, out_valid and ready_q.
      unique case (state)
        ST_EMPTY: begin
          if (xfer_in) begin
            state     <= ST_FULL;
            out_valid <= 1'b1;
            out_data  <= in_data;
          end
        end
        ST_FULL: begin
          if (xfer_in && xfer_out) begin
            out_data <= in_data;
          end else if (xfer_in) begin
            state     <= ST_SKID;
            skid_data <= in_data;
            ready_q   <= 1'b0;
          end else if (xfer_out) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so only the drain can happen.
          if (xfer_out) begin
            state    <= ST_FULL;
            out_data <= skid_data;
            ready_q  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          ready_q   <= 1'b1;
        end
      endcase
    end
  end

`else

  // Single entry: a new beat can enter when the slot is empty or is being
  // drained in the same cycle.
  assign in_ready = ~flush & (out_ready | ~out_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is reset too, so no payload from before a
      // reset can reappear on out_data.
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer_in) begin
      // NOTE: non-blocking assignments, so this branch uses the pre-edge
      // out_valid that in_ready was computed from.
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      // Bubble: the held beat left and nothing replaced it.
      out_valid <= 1'b0;
    end
  end

`endif

  // Stall counter: counts edges where a beat is offered but refused.
  // Flush cycles are excluded; only reset clears the count.
  logic stall_now;
  assign stall_now = out_valid & ~out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_now && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_hs
//
// Self-checking bench for pipe_stage_hs.  A queue-based reference model
// holds the beats currently inside the stage (capacity 1, or 2 with
// PIPE_SKID_EN) and predicts in_ready, out_valid, out_data and stall_cnt.
// A second instance with CNT_W=3 shares the stimulus for the saturation
// check.
// ---------------------------------------------------------------------------
module tb_pipe_stage_hs;

  localparam int DW = 32;
  localparam int CW = 16;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cnt;

  logic          in_ready3;
  logic          out_valid3;
  logic [DW-1:0] out_data3;
  logic [2:0]    stall_cnt3;

  pipe_stage_hs #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  pipe_stage_hs #(.DATA_W(DW), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .flush(flush), .stall_cnt(stall_cnt3)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  logic [DW-1:0] q[$];        // beats held, head first
  logic [DW-1:0] last_head;   // payload shown when the stage is empty
  int unsigned   m_stall;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic bit m_in_ready();
    if (flush) return 1'b0;
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  task automatic model_reset();
    q.delete();
    last_head = '0;
    m_stall   = 0;
  endtask

  // Advance the model across one rising edge using the inputs in force.
  task automatic model_edge();
    bit xi;
    bit xo;
    xi = in_valid && m_in_ready();
    xo = (q.size() > 0) && out_ready;
    if ((q.size() > 0) && !out_ready && !flush && (m_stall < (2**CW - 1)))
      m_stall++;
    if (flush) begin
      q.delete();
    end else begin
      if (xo) void'(q.pop_front());
      if (xi) q.push_back(in_data);
    end
    if (q.size() > 0) last_head = q[0];
  endtask

  // One clock: drive, check in_ready before the edge, check outputs after.
  task automatic cycle(input bit v, input bit r, input bit f,
                       input logic [DW-1:0] d, output bit ir_pre);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    in_data   = d;
    #1;
    ir_pre = in_ready;
    check("in_ready", in_ready, m_in_ready());
    @(posedge clk);
    model_edge();
    #1;
    check("out_valid", out_valid, q.size() > 0);
    check("out_data", out_data, (q.size() > 0) ? q[0] : last_head);
    check("stall_cnt", stall_cnt, m_stall);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit            v;
    bit            r;
    bit            f;
    logic [DW-1:0] d;
    bit            exp_valid;
    logic [DW-1:0] exp_data;
    bit            exp_in_ready;
  } vec_t;

  vec_t tbl[9];

  initial begin
    bit ir;

    // Reset state while rst_n is held low from time zero.
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_stall_cnt", stall_cnt, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Streaming 0x1..0x8 with no gaps, then a bubble.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 1'b1, 1'b0, DW'(i + 1), 1'b1, DW'(i + 1), 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b0, '0, 1'b0, DW'(8), 1'b1};
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].d, ir);
      check($sformatf("tbl%0d_in_ready", i), ir, tbl[i].exp_in_ready);
      check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].exp_valid);
      check($sformatf("tbl%0d_out_data", i), out_data, tbl[i].exp_data);
    end

    // Stall: 0xA5 held for 5 cycles while 0x5A is offered.
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'hA5, ir);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h5A, ir);
      check($sformatf("stall_in_ready%0d", i), ir, SKID && (i == 0));
      check("stall_out_data", out_data, 32'hA5);
      check("stall_out_valid", out_valid, 1'b1);
    end
    check("stall_cnt_5", stall_cnt, 5);
    check("stall_cnt3_5", stall_cnt3, 3'd5);

    // Saturation of the 3-bit counter: 10 stalled cycles in total.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h5A, ir);
      if (i == 1) check("sat_cnt3_7", stall_cnt3, 3'd7);
    end
    check("sat_cnt3_hold", stall_cnt3, 3'd7);
    check("sat_cnt_10", stall_cnt, 10);

    // Flush with held beat(s) and a new beat offered.
    cycle(1'b1, 1'b1, 1'b1, 32'hEE, ir);
    check("flush_in_ready", ir, 1'b0);
    check("flush_out_valid", out_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, '0, ir);
      check("post_flush_valid", out_valid, 1'b0);
      check("post_flush_data", out_data, 32'hA5);
    end
    check("flush_stall_kept", stall_cnt, 10);

    // Asynchronous reset in the middle of a transfer.
    cycle(1'b1, 1'b1, 1'b0, 32'h11, ir);
    in_data = 32'h22;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_out_data", out_data, '0);
    check("async_stall_cnt", stall_cnt, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1;
    check("async_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Random traffic against the reference queue.
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 32) == 0,
            $urandom, ir);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
